// File: rtl/lfsr_histogram_binner_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : histo_pkg
//  Description : Shared constants and helpers for the LFSR histogram binner:
//                bin geometry, record header and record packing.
//  Revision    : 1.0  initial release
// ============================================================================
package histo_pkg;

    localparam int          NUM_BINS   = 8;
    localparam int          BIN_W      = 3;
    localparam int          CNT_W      = 8;
    localparam logic [11:0] BIN_BASE   = 12'h020;
    localparam logic [11:0] BIN_STRIDE = 12'h020;
    localparam logic [3:0]  PKT_HDR    = 4'h0;
    localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

    // Storage address of a bin; arithmetic deliberately wraps in 12 bits.
    function automatic logic [11:0] bin_addr(
        input logic [BIN_W-1:0] bin,
        input logic [11:0]      base   = BIN_BASE,
        input logic [11:0]      stride = BIN_STRIDE
    );
        logic [11:0] w_bin_ext;
        w_bin_ext = {{(12-BIN_W){1'b0}}, bin};
        return base + (w_bin_ext * stride);
    endfunction

    // Record layout: {header, count, storage address, raw sample}.
    function automatic logic [31:0] pack_record(
        input logic [CNT_W-1:0] count,
        input logic [11:0]      addr,
        input logic [7:0]       value
    );
        return {PKT_HDR, count, addr, value};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_histogram_binner_count_bank.sv
`default_nettype none
// ============================================================================
//  Module      : histo_count_bank
//  Description : Eight saturating 8-bit occurrence counters with sticky
//                per-bin overflow flags. Provides the post-increment count of
//                the addressed bin combinationally so the record can carry it
//                on the same edge the counter updates.
//  Ports       : aclk, aresetn     clock / async active-low reset
//                inc_en, inc_bin   increment request and target bin
//                clear             synchronous zero of all counters/flags
//                next_count        count inc_bin will hold after this edge
//                overflow          sticky per-bin saturation flags
//  Revision    : 1.0  initial release
// ============================================================================
module histo_count_bank
    import histo_pkg::*;
(
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 inc_en,
    input  logic [BIN_W-1:0]     inc_bin,
    input  logic                 clear,
    output logic [CNT_W-1:0]     next_count,
    output logic [NUM_BINS-1:0]  overflow
);

    logic [CNT_W-1:0] w_counts [NUM_BINS];
    logic [CNT_W-1:0] w_cur;

    generate
        for (genvar i = 0; i < NUM_BINS; i++) begin : g_bin
            logic             w_hit;
            logic [CNT_W-1:0] r_count;
            logic             r_ovf;

            // One-hot decode: each counter only looks at its own hit line.
            assign w_hit = inc_en && (inc_bin == BIN_W'(i));

            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    r_count <= '0;
                    r_ovf   <= 1'b0;
                end else if (clear) begin
                    // A sample arriving with clear counts as the first one.
                    r_count <= w_hit ? CNT_W'(1) : '0;
                    r_ovf   <= 1'b0;
                end else if (w_hit) begin
                    if (r_count == CNT_MAX) begin
                        r_ovf <= 1'b1;
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
            end

            assign w_counts[i]  = r_count;
            assign overflow[i]  = r_ovf;
        end
    endgenerate

    assign w_cur = w_counts[inc_bin];

    always_comb begin
        next_count = w_cur + CNT_W'(1);
        if (clear) begin
            next_count = CNT_W'(1);
        end else if (w_cur == CNT_MAX) begin
            next_count = CNT_MAX;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lfsr_histogram_binner.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_histogram_binner
//  Description : Classifies 8-bit LFSR samples into 8 bins by their top three
//                bits, keeps saturating per-bin counts and emits one 32-bit
//                record {4'h0, count, addr, sample} per accepted sample.
//  Ports       : aclk, aresetn           clock / async active-low reset
//                s_axis_*                sample stream in (8-bit)
//                m_axis_*                record stream out (32-bit)
//                clear                   zero counts, overflow, sample_total
//                overflow                sticky per-bin saturation flags
//                sample_total            accepted-sample counter (wrapping)
//  Revision    : 1.0  initial release
// ============================================================================
module lfsr_histogram_binner #(
    parameter logic [11:0] BIN_BASE   = histo_pkg::BIN_BASE,
    parameter logic [11:0] BIN_STRIDE = histo_pkg::BIN_STRIDE
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    input  logic        clear,
    output logic [7:0]  overflow,
    output logic [15:0] sample_total
);

    import histo_pkg::*;

    logic              w_slot_free;
    logic              w_accept;
    logic [BIN_W-1:0]  w_bin;
    logic [11:0]       w_addr;
    logic [CNT_W-1:0]  w_next_count;

    logic [31:0]       r_tdata;
    logic              r_tvalid;
    logic [15:0]       r_total;

    // One-deep output slot: a new sample may enter whenever the slot is empty
    // or is being drained on this same edge. The reset term only gates the
    // visible ready; internally the flops are held in reset anyway.
    assign w_slot_free   = !r_tvalid || m_axis_tready;
    assign w_accept      = s_axis_tvalid && w_slot_free;
    assign s_axis_tready = aresetn && w_slot_free;

    assign w_bin  = s_axis_tdata[7:5];
    assign w_addr = bin_addr(w_bin, BIN_BASE, BIN_STRIDE);

    histo_count_bank u_count_bank (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .inc_en     (w_accept),
        .inc_bin    (w_bin),
        .clear      (clear),
        .next_count (w_next_count),
        .overflow   (overflow)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
        end else if (w_accept) begin
            r_tdata  <= pack_record(w_next_count, w_addr, s_axis_tdata);
            r_tvalid <= 1'b1;
        end else if (m_axis_tready) begin
            r_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_total <= '0;
        end else if (clear) begin
            r_total <= w_accept ? 16'd1 : 16'd0;
        end else if (w_accept) begin
            r_total <= r_total + 16'd1;
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign sample_total  = r_total;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_histogram_binner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr_histogram_binner
//  Description : Scoreboard bench for lfsr_histogram_binner. The driver keeps
//                a plain-arithmetic histogram model and queues the expected
//                record of every accepted sample; an independent monitor
//                compares whatever the DUT presents against the queue head.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lfsr_histogram_binner;

    logic        aclk          = 1'b0;
    logic        aresetn       = 1'b0;
    logic [7:0]  s_axis_tdata  = 8'h00;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        clear         = 1'b0;
    logic [7:0]  overflow;
    logic [15:0] sample_total;

    lfsr_histogram_binner dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .clear         (clear),
        .overflow      (overflow),
        .sample_total  (sample_total)
    );

    always #5 aclk = ~aclk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] q [$];
    int          m_cnt [8];
    logic [7:0]  m_ovf;
    logic [15:0] m_total;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_zero();
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_ovf   = 8'h00;
        m_total = 16'h0000;
    endtask

    // One bus cycle: inputs applied at the falling edge, model updated just
    // after the following rising edge.
    task automatic drive(input logic v, input logic [7:0] d, input logic rdy, input logic clr);
        logic exp_rdy;
        logic acc;
        int   b;
        @(negedge aclk);
        check("sample_total", 32'(sample_total), 32'(m_total));
        check("overflow", 32'(overflow), 32'(m_ovf));
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        m_axis_tready = rdy;
        clear         = clr;
        #1;
        exp_rdy = aresetn && ((q.size() == 0) || rdy);
        check("s_axis_tready", 32'(s_axis_tready), 32'(exp_rdy));
        acc = v && exp_rdy;
        @(posedge aclk);
        #1;
        if (clr) model_zero();
        if (acc) begin
            b = int'(d[7:5]);
            if (m_cnt[b] == 255) m_ovf[b] = 1'b1;
            else                 m_cnt[b] = m_cnt[b] + 1;
            q.push_back({4'h0, 8'(m_cnt[b]), 12'(32 + 32 * b), d});
            m_total = m_total + 16'd1;
        end
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn       = 1'b0;
        s_axis_tvalid = 1'b0;
        clear         = 1'b0;
        m_axis_tready = 1'b1;
        q.delete();
        model_zero();
        #1;
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tdata", m_axis_tdata, 32'h0);
        check("rst_s_tready", 32'(s_axis_tready), 32'd0);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
    endtask

    // Monitor: a record is expected exactly when the scoreboard holds one.
    initial begin
        forever begin
            @(negedge aclk);
            #3;
            check("m_axis_tvalid", 32'(m_axis_tvalid), 32'(q.size() != 0));
            if (m_axis_tvalid && (q.size() != 0)) begin
                check("m_axis_tdata", m_axis_tdata, q[0]);
                if (m_axis_tready) void'(q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_zero();
        #2;
        check("init_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("init_tdata", m_axis_tdata, 32'h0);
        check("init_s_tready", 32'(s_axis_tready), 32'd0);
        check("init_total", 32'(sample_total), 32'd0);
        check("init_overflow", 32'(overflow), 32'd0);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;

        // First sample right after release.
        drive(1'b1, 8'h42, 1'b1, 1'b0);
        check("rec_42", m_axis_tdata, 32'h00106042);
        check("total_after_42", 32'(sample_total), 32'd1);

        // Back-to-back samples in three bins.
        drive(1'b1, 8'h00, 1'b1, 1'b0);
        check("rec_00", m_axis_tdata, 32'h00102000);
        drive(1'b1, 8'hFF, 1'b1, 1'b0);
        check("rec_FF", m_axis_tdata, 32'h001100FF);
        drive(1'b1, 8'h1F, 1'b1, 1'b0);
        check("rec_1F", m_axis_tdata, 32'h0020201F);
        drive(1'b0, 8'h00, 1'b1, 1'b0);

        // Back-pressure: record held, nothing accepted, then released.
        drive(1'b1, 8'h11, 1'b0, 1'b0);
        repeat (3) drive(1'b1, 8'h33, 1'b0, 1'b0);
        drive(1'b1, 8'h33, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);

        // Saturation of bin 5.
        do_reset();
        repeat (254) drive(1'b1, 8'hA0, 1'b1, 1'b0);
        drive(1'b1, 8'hA0, 1'b1, 1'b0);
        check("rec_sat_255", m_axis_tdata, 32'h0FF0C0A0);
        drive(1'b1, 8'hA0, 1'b1, 1'b0);
        check("rec_sat_256", m_axis_tdata, 32'h0FF0C0A0);
        check("overflow_sat", 32'(overflow), 32'h20);

        // Clear coincident with a sample.
        repeat (5) drive(1'b1, 8'h60, 1'b1, 1'b0);
        drive(1'b1, 8'h60, 1'b1, 1'b1);
        check("rec_clear", m_axis_tdata, 32'h00108060);
        check("total_clear", 32'(sample_total), 32'd1);
        check("overflow_clear", 32'(overflow), 32'd0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);

        // Reset while a record is stalled.
        drive(1'b1, 8'h42, 1'b0, 1'b0);
        drive(1'b1, 8'h42, 1'b0, 1'b0);
        do_reset();
        drive(1'b1, 8'h42, 1'b1, 1'b0);
        check("rec_after_reset", m_axis_tdata, 32'h00106042);

        // Randomised traffic with occasional clears and one reset.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 49) == 0);
        end

        drive(1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
